// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin on ties, bus lock while the owner holds cyc.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module wb_master_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o
);

    // Handshake: a master request is cyc; a transfer completes on the cycle the
    // slave (or the timeout) presents ack/err while the owner's stb is high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // 1 = master 1 was granted most recently
    logic   timeout_hit;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_master_arbiter: TIMEOUT must be within 1..65535");
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt_q;
    logic        own_stb;
    logic        stalled;

    assign own_stb = (state_q == GNT0) ? m0_stb_i :
                     (state_q == GNT1) ? m1_stb_i : 1'b0;
    assign stalled = own_stb && !s_ack_i && !s_err_i;
    // Fires on the TIMEOUT-th consecutive stalled cycle of the current owner.
    assign timeout_hit = stalled && (to_cnt_q == TO_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q == IDLE || timeout_hit || s_ack_i || s_err_i) begin
            to_cnt_q <= 16'd0;
        end else if (stalled) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: if (!m0_cyc_i || timeout_hit) state_d = IDLE;
            GNT1: if (!m1_cyc_i || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_sel_o  = 4'd0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = 2'b00;
        case (state_q)
            GNT0: begin
                grant_o  = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i && !timeout_hit;
                s_stb_o  = m0_stb_i && !timeout_hit;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || timeout_hit;
            end
            GNT1: begin
                grant_o  = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i && !timeout_hit;
                s_stb_o  = m1_stb_i && !timeout_hit;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || timeout_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning stalled-cycle limit in clocks (legal range 1..65535, used only with WB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports mN_adr_i  input  32  master N address (N=0 core data port, N=1 boot/DMA master).
REQ-005 SHALL have ports mN_dat_i  input  32  master N write data.
REQ-006 SHALL have ports mN_sel_i  input  4  master N byte select.
REQ-007 SHALL have ports mN_we_i  input  1  master N write enable.
REQ-008 SHALL have ports mN_cyc_i / mN_stb_i  input  1 each  master N cycle / strobe.
REQ-009 SHALL have ports mN_dat_o  output  32  read data returned to master N.
REQ-010 SHALL have ports mN_ack_o / mN_err_o  output  1 each  termination to master N.
REQ-011 SHALL have ports s_adr_o, s_dat_o (32), s_sel_o (4), s_we_o, s_cyc_o, s_stb_o (1)  output  shared master port toward the interconnect.
REQ-012 SHALL have ports s_dat_i (32), s_ack_i, s_err_i (1)  input  interconnect response.
REQ-013 SHALL have port grant_o  output  2  one-hot current owner, bit N = master N.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1; grant_o = 2'b00 in IDLE, 2'b01 in GNT0, 2'b10 in GNT1.
REQ-015 In IDLE, a single requester (mN_cyc_i=1) SHALL be granted on the next edge; request-to-s_cyc_o latency is exactly 1 cycle.
REQ-016 In IDLE with both requesting, grant SHALL go to the master not granted last (round-robin); the last-grant register SHALL update on every IDLE->GNTn transition.
REQ-017 In GNTn, s_adr/dat/sel/we/cyc/stb_o SHALL combinationally equal the granted master's inputs; otherwise s_* outputs SHALL be 0.
REQ-018 Granted master SHALL receive mN_dat_o=s_dat_i, mN_ack_o=s_ack_i, mN_err_o=s_err_i (plus timeout err, REQ-024); non-granted master SHALL see dat_o=0, ack_o=0, err_o=0.
REQ-019 Ownership SHALL be held while the granted mN_cyc_i stays 1 (bus lock across back-to-back and burst transfers); the other master's request SHALL wait, not be dropped.
REQ-020 When the granted mN_cyc_i is 0 at an edge, FSM SHALL return to IDLE; minimum one IDLE cycle between owners.
REQ-021 A master deasserting cyc before grant SHALL be treated as no request; no state effect.
REQ-022 Arbiter SHALL NOT generate ack itself; only slave or timeout terminations reach masters.

Reset
REQ-023 While wb_rst_i=1 at an edge: state=IDLE, last-grant=master 1 (so master 0 wins first tie), timeout counter=0; all outputs 0 in the following cycle, including mid-transfer reset.

Configuration
REQ-024 With macro WB_ARB_TIMEOUT_EN defined: counter SHALL increment each GNTn cycle with s_stb_o=1 and s_ack_i=s_err_i=0, clear on ack/err or IDLE; on reaching TIMEOUT it SHALL assert mN_err_o for exactly one cycle, force s_cyc_o=s_stb_o=0 that cycle, and go to IDLE.
REQ-025 Without WB_ARB_TIMEOUT_EN: no counter logic; a stalled slave holds ownership indefinitely; mN_err_o reflects s_err_i only.

Verification
REQ-026 m0 reads 0x0000_1000, s_ack_i after 2 cycles with s_dat_i=0xDEADBEEF -> grant_o=01 one cycle after cyc, m0_dat_o=0xDEADBEEF with m0_ack_o, m1 outputs 0.
REQ-027 Both cyc rise same cycle after reset -> GNT0 first; after m0 drops cyc, IDLE 1 cycle, then GNT1; next tie -> GNT0.
REQ-028 m0 holds cyc for 4 back-to-back acked transfers while m1 requests -> grant_o stays 01 for all 4; m1 granted only after m0 cyc=0 plus 1 IDLE cycle.
REQ-029 Reset asserted during GNT1 with stb pending -> next cycle grant_o=00, s_cyc_o=0, all mN_ack_o/err_o=0.
REQ-030 WB_ARB_TIMEOUT_EN, TIMEOUT=8, m1 strobes with no ack -> m1_err_o=1 for one cycle on the 8th stalled cycle, s_cyc_o=0 same cycle, then IDLE; without macro, grant_o stays 10 for 100 cycles.
